// File: rtl/fir_pkg.sv
// Shared definitions for the FIR datapath: controller state encoding and
// the default filter geometry used by both the tap feeder and the MAC unit.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } fir_state_t;

  localparam int FIR_ORDER      = 8;
  localparam int FIR_DATA_WIDTH = 13;

endpackage

// File: rtl/fir_delay_line.sv
// Parameterised shift register holding the FIR tap window. Element 0 is
// the newest sample. Clear has priority over shift.
module fir_delay_line #(
  parameter int DEPTH      = 9,
  parameter int DATA_WIDTH = 13
) (
  input  logic                         clk,
  input  logic                         srst,
  input  logic                         shift_en,
  input  logic                         clear,
  input  logic signed [DATA_WIDTH-1:0] din,
  output logic signed [DATA_WIDTH-1:0] taps [0:DEPTH-1]
);

  logic signed [DATA_WIDTH-1:0] tap_reg [0:DEPTH-1];

  // Shift a new sample in at the head, or wipe the whole window.
  always_ff @(posedge clk) begin
    if (srst || clear) begin
      for (int i = 0; i < DEPTH; i++) tap_reg[i] <= '0;
    end else if (shift_en) begin
      tap_reg[0] <= din;
      for (int i = 1; i < DEPTH; i++) tap_reg[i] <= tap_reg[i-1];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_out
      assign taps[gi] = tap_reg[gi];
    end
  endgenerate

endmodule

// File: rtl/fir_tap_feeder.sv
// FIR front end: accepts samples into the tap window, loads coefficients
// into a shadow bank and commits them to H in a single cycle, and strobes
// TAP_V whenever a sample completes a full window.
module fir_tap_feeder
  import fir_pkg::*;
#(
  parameter int ORDER      = FIR_ORDER,
  parameter int DATA_WIDTH = FIR_DATA_WIDTH
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic signed [DATA_WIDTH-1:0] DIN,
  input  logic                         VIN,
  output logic                         RDY,
  input  logic                         CFG_START,
  input  logic signed [DATA_WIDTH-1:0] COEF_DIN,
  input  logic                         COEF_V,
  output logic                         CFG_DONE,
  input  logic                         FLUSH,
  output logic signed [DATA_WIDTH-1:0] tp_w [0:ORDER],
  output logic signed [DATA_WIDTH-1:0] H    [0:ORDER],
  output logic                         TAP_V
);

  localparam int NTAPS  = ORDER + 1;
  localparam int IDX_W  = $clog2(ORDER + 1);
  localparam int FILL_W = $clog2(ORDER + 2);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(ORDER);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(NTAPS);

  fir_state_t                   state_reg;
  logic [IDX_W-1:0]             idx_reg;
  logic [FILL_W-1:0]            fill_reg;
  logic [FILL_W-1:0]            fill_next;
  logic signed [DATA_WIDTH-1:0] shadow_reg [0:ORDER];
  logic signed [DATA_WIDTH-1:0] h_reg      [0:ORDER];
  logic                         tap_v_reg;
  logic                         cfg_done_reg;

  logic accept;
  logic clear_taps;
  logic shift_en;
  logic coef_we;
  logic coef_last;

  // A CFG_START in the same cycle blocks the sample so reconfiguration
  // never races an in-flight accept.
  assign RDY        = (state_reg == RUN) && !CFG_START;
  assign accept     = VIN && RDY;
  assign clear_taps = CFG_START || FLUSH;
  assign shift_en   = accept && !clear_taps;
  assign coef_we    = (state_reg == LOAD) && !CFG_START && COEF_V;
  assign coef_last  = coef_we && (idx_reg == IDX_LAST);
  assign fill_next  = (fill_reg == FILL_FULL) ? fill_reg : fill_reg + 1'b1;

  // Controller: CFG_START always (re)enters LOAD; last coefficient enters RUN.
  always_ff @(posedge CLK) begin
    if (RST)            state_reg <= IDLE;
    else if (CFG_START) state_reg <= LOAD;
    else if (coef_last) state_reg <= RUN;
  end

  // Coefficient index: restarts on CFG_START, wraps after the commit.
  always_ff @(posedge CLK) begin
    if (RST || CFG_START) idx_reg <= '0;
    else if (coef_we)     idx_reg <= coef_last ? '0 : idx_reg + 1'b1;
  end

  // Shadow bank collects words one per cycle while loading.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NTAPS; i++) shadow_reg[i] <= '0;
    end else if (coef_we) begin
      shadow_reg[idx_reg] <= COEF_DIN;
    end
  end

  // Committed bank: the final word bypasses the shadow so H updates on the
  // same edge as that word, with every element changing together.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NTAPS; i++) h_reg[i] <= '0;
    end else if (coef_last) begin
      for (int i = 0; i < NTAPS; i++) h_reg[i] <= (i == ORDER) ? COEF_DIN : shadow_reg[i];
    end
  end

  // Fill count saturates at a full window and clears with the window.
  always_ff @(posedge CLK) begin
    if (RST || clear_taps) fill_reg <= '0;
    else if (shift_en)     fill_reg <= fill_next;
  end

  // Registered strobes: window-complete and bank-committed.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tap_v_reg    <= 1'b0;
      cfg_done_reg <= 1'b0;
    end else begin
      tap_v_reg    <= shift_en && (fill_next == FILL_FULL);
      cfg_done_reg <= coef_last;
    end
  end

  assign TAP_V    = tap_v_reg;
  assign CFG_DONE = cfg_done_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NTAPS; gi++) begin : g_h
      assign H[gi] = h_reg[gi];
    end
  endgenerate

  fir_delay_line #(
    .DEPTH      (NTAPS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_delay_line (
    .clk      (CLK),
    .srst     (RST),
    .shift_en (shift_en),
    .clear    (clear_taps),
    .din      (DIN),
    .taps     (tp_w)
  );

endmodule
